// File: rtl/fcw_sequencer.sv
// Purpose: steps through the 4-entry FCW RAM, holds each note for CYCLES_PER_NOTE cycles, writes edited FCWs back.
// Latency: read issued in FETCH, fcw updated at end of LOAD; note period is CYCLES_PER_NOTE+2 cycles (+1 per edit).
// Backpressure: none; edit/play_pause pulses arriving in busy states (FETCH/LOAD/WRITE) are dropped, not queued.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   play_pause               pulse: IDLE->start, PLAY<->PAUSE
//   reverse                  level, sampled at the note-advance edge
//   edit_up / edit_down      pulses: +/- FCW_STEP on the current note (saturating)
//   ram_rd_en/ram_wr_en/ram_addr/ram_wr_data/ram_rd_data   FCW RAM port (1-cycle read latency)
//   fcw, fcw_valid, note_idx NCO drive and current note index
//
// Optional feature macro FCW_SEQ_ONESHOT_EN: when defined, a wrapping advance
// (3->0 forward, 0->3 reverse) parks in IDLE instead of fetching the next note.
module fcw_sequencer #(
    parameter int CYCLES_PER_NOTE = 12500000,
    parameter int FCW_STEP        = 16,
    parameter int COUNT_W         = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_pause,
    input  logic        reverse,
    input  logic        edit_up,
    input  logic        edit_down,
    output logic        ram_rd_en,
    output logic        ram_wr_en,
    output logic [1:0]  ram_addr,
    output logic [23:0] ram_wr_data,
    input  logic [23:0] ram_rd_data,
    output logic [23:0] fcw,
    output logic        fcw_valid,
    output logic [1:0]  note_idx
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        PAUSE = 3'd4,
        WRITE = 3'd5
    } state_t;

    localparam logic [COUNT_W-1:0] COUNT_LOAD = COUNT_W'(CYCLES_PER_NOTE - 1);
    localparam logic [24:0]        STEP25     = 25'(FCW_STEP);

    state_t             state, state_nxt;
    logic [COUNT_W-1:0] count, count_nxt;
    logic [1:0]         idx, idx_nxt;
    logic [23:0]        fcw_q, fcw_nxt;
    logic [23:0]        wr_q, wr_nxt;
    logic               valid_q, valid_nxt;
    logic               ret_play, ret_nxt;   // 1: WRITE returns to PLAY, 0: to PAUSE

    logic        edit_one;
    logic [24:0] sum_up, dif_dn;
    logic [23:0] edit_val;
    logic [1:0]  idx_adv;
    logic        wrap;

    // Simultaneous up+down cancels out rather than picking a winner.
    assign edit_one = edit_up ^ edit_down;

    // 25-bit arithmetic: bit 24 flags carry (up) or borrow (down) for saturation.
    assign sum_up   = {1'b0, fcw_q} + STEP25;
    assign dif_dn   = {1'b0, fcw_q} - STEP25;
    assign edit_val = edit_up ? (sum_up[24] ? 24'hFFFFFF : sum_up[23:0])
                              : (dif_dn[24] ? 24'h000000 : dif_dn[23:0]);

    assign idx_adv  = reverse ? (idx - 2'd1) : (idx + 2'd1);
    assign wrap     = reverse ? (idx == 2'd0) : (idx == 2'd3);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        idx_nxt   = idx;
        fcw_nxt   = fcw_q;
        wr_nxt    = wr_q;
        valid_nxt = valid_q;
        ret_nxt   = ret_play;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (play_pause) state_nxt = FETCH;
            end
            FETCH: state_nxt = LOAD;
            LOAD: begin
                fcw_nxt   = ram_rd_data;
                count_nxt = COUNT_LOAD;
                valid_nxt = 1'b1;
                state_nxt = PLAY;
            end
            PLAY: begin
                if (count != '0) count_nxt = count - COUNT_W'(1);
                if (play_pause) begin
                    state_nxt = PAUSE;
                    valid_nxt = 1'b0;
                end else if (count == '0) begin
                    idx_nxt   = idx_adv;
                    state_nxt = FETCH;
`ifdef FCW_SEQ_ONESHOT_EN
                    if (wrap) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                    end
`endif
                end else if (edit_one) begin
                    wr_nxt    = edit_val;
                    ret_nxt   = 1'b1;
                    state_nxt = WRITE;
                end
            end
            PAUSE: begin
                if (play_pause) begin
                    state_nxt = PLAY;
                    valid_nxt = 1'b1;
                end else if (edit_one) begin
                    wr_nxt    = edit_val;
                    ret_nxt   = 1'b0;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                fcw_nxt   = wr_q;
                state_nxt = ret_play ? PLAY : PAUSE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            idx      <= 2'd0;
            fcw_q    <= 24'd0;
            wr_q     <= 24'd0;
            valid_q  <= 1'b0;
            ret_play <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            idx      <= idx_nxt;
            fcw_q    <= fcw_nxt;
            wr_q     <= wr_nxt;
            valid_q  <= valid_nxt;
            ret_play <= ret_nxt;
        end
    end

    // All outputs decode registered state only.
    assign ram_rd_en   = (state == FETCH);
    assign ram_wr_en   = (state == WRITE);
    assign ram_addr    = (state == FETCH || state == WRITE) ? idx : 2'd0;
    assign ram_wr_data = wr_q;
    assign fcw         = fcw_q;
    assign fcw_valid   = valid_q;
    assign note_idx    = idx;

    // A wrap only matters in one-shot builds.
`ifndef FCW_SEQ_ONESHOT_EN
    logic unused_wrap;
    assign unused_wrap = wrap;
`endif

endmodule

// File: tb/tb_fcw_sequencer.sv
module tb_fcw_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        play_pause = 1'b0;
    logic        reverse = 1'b0;
    logic        edit_up = 1'b0;
    logic        edit_down = 1'b0;
    logic        ram_rd_en, ram_wr_en;
    logic [1:0]  ram_addr;
    logic [23:0] ram_wr_data;
    logic [23:0] ram_rd_data;
    logic [23:0] fcw;
    logic        fcw_valid;
    logic [1:0]  note_idx;

    // bench-side RAM controls
    logic        ram_init = 1'b0;
    logic        pre_en = 1'b0;
    logic [1:0]  pre_addr = 2'd0;
    logic [23:0] pre_data = 24'd0;
    logic [23:0] mem [4];

    int errors = 0;
    int checks = 0;

    logic [1:0]  exp_rd_q  [$];
    logic [25:0] exp_wr_q  [$];
    logic [23:0] exp_fcw_q [$];
    logic [1:0]  rd_hist = 2'b00;

    always #5 clk = ~clk;

    fcw_sequencer #(
        .CYCLES_PER_NOTE(4),
        .FCW_STEP(16),
        .COUNT_W(24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .play_pause(play_pause),
        .reverse(reverse),
        .edit_up(edit_up),
        .edit_down(edit_down),
        .ram_rd_en(ram_rd_en),
        .ram_wr_en(ram_wr_en),
        .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data),
        .fcw(fcw),
        .fcw_valid(fcw_valid),
        .note_idx(note_idx)
    );

    // 4-entry synchronous RAM, read data valid the cycle after ram_rd_en.
    always @(posedge clk) begin
        if (ram_init) begin
            mem[0] <= 24'h00EC3C;
            mem[1] <= 24'h010905;
            mem[2] <= 24'h01194B;
            mem[3] <= 24'h013BCD;
        end else if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_wr_en) begin
            mem[ram_addr] <= ram_wr_data;
        end
        if (ram_rd_en) ram_rd_data <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT reads, writes, or lands a freshly loaded note.
    always @(negedge clk) begin
        if (rst) begin
            rd_hist = 2'b00;
        end else begin
            if (rd_hist[1]) begin
                if (exp_fcw_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_load: got fcw %h required none", fcw);
                end else begin
                    check("fcw_load", 32'({fcw_valid, fcw}), 32'({1'b1, exp_fcw_q.pop_front()}));
                end
            end
            rd_hist = {rd_hist[0], ram_rd_en};
            if (ram_rd_en || ram_wr_en)
                check("rd_wr_exclusive", 32'(ram_rd_en & ram_wr_en), 0);
            if (ram_rd_en) begin
                if (exp_rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got addr %0d required none", ram_addr);
                end else begin
                    check("ram_read_addr", 32'(ram_addr), 32'(exp_rd_q.pop_front()));
                end
            end
            if (ram_wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %0d data %h required none", ram_addr, ram_wr_data);
                end else begin
                    check("ram_write", 32'({ram_addr, ram_wr_data}), 32'(exp_wr_q.pop_front()));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_pp;
        play_pause = 1'b1;
        tick();
        play_pause = 1'b0;
    endtask

    task automatic expect_note(input logic [1:0] a, input logic [23:0] f);
        exp_rd_q.push_back(a);
        exp_fcw_q.push_back(f);
    endtask

    // From any cycle, advance to the next FETCH cycle (bounded).
    task automatic wait_fetch(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ram_rd_en && n < 40);
        check("fetch_seen", 32'(ram_rd_en), 1);
    endtask

    // From a FETCH cycle of note 3 (forward) or 0 (reverse), get to the wrapped note's FETCH.
    task automatic wrap_fetch;
        int n;
`ifdef FCW_SEQ_ONESHOT_EN
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!(seen && !fcw_valid) && n < 40) begin
            tick();
            n++;
            if (fcw_valid) seen = 1'b1;
        end
        check("oneshot_idle_valid", 32'(fcw_valid), 0);
        repeat (2) tick();
        check("oneshot_idle_no_fetch", 32'(ram_rd_en), 0);
        pulse_pp();
        check("oneshot_restart_fetch", 32'(ram_rd_en), 1);
`else
        wait_fetch(n);
`endif
    endtask

    initial begin
        int n;

        // ---------------- reset state ----------------
        rst = 1'b1;
        ram_init = 1'b1;
        tick();
        ram_init = 1'b0;
        tick();
        check("reset_ctrl", 32'({fcw_valid, ram_rd_en, ram_wr_en, ram_addr, note_idx}), 0);
        check("reset_fcw", 32'(fcw), 0);
        check("reset_wr_data", 32'(ram_wr_data), 0);
        rst = 1'b0;
        tick();

        // ---------------- 1/2: start and walk all four notes ----------------
        expect_note(2'd0, 24'h00EC3C);
        expect_note(2'd1, 24'h010905);
        expect_note(2'd2, 24'h01194B);
        expect_note(2'd3, 24'h013BCD);
`ifndef FCW_SEQ_ONESHOT_EN
        expect_note(2'd0, 24'h00EC3C);
`endif
        pulse_pp();                                   // now in cycle 1
        check("t1_c1_rd_en", 32'(ram_rd_en), 1);
        check("t1_c1_addr", 32'(ram_addr), 0);
        tick();                                       // cycle 2
        check("t1_c2_valid", 32'(fcw_valid), 0);
        tick();                                       // cycle 3
        check("t1_c3_fcw", 32'({fcw_valid, fcw}), 32'({1'b1, 24'h00EC3C}));
        repeat (4) tick();                            // cycle 7
        check("t1_c7_rd_addr1", 32'({ram_rd_en, ram_addr}), 32'({1'b1, 2'd1}));
        repeat (18) tick();                           // cycle 25
`ifdef FCW_SEQ_ONESHOT_EN
        check("t2_oneshot_idle", 32'({fcw_valid, ram_rd_en, note_idx}), 0);
        expect_note(2'd0, 24'h00EC3C);
        pulse_pp();
        check("t2_restart_fetch", 32'({ram_rd_en, ram_addr}), 32'({1'b1, 2'd0}));
`else
        check("t2_wrap_fetch0", 32'({ram_rd_en, ram_addr}), 32'({1'b1, 2'd0}));
`endif

        // ---------------- 3: reverse from note 0 -> note 3 ----------------
        reverse = 1'b1;
        expect_note(2'd3, 24'h013BCD);
        wrap_fetch();
        reverse = 1'b0;
        check("t3_rev_addr3", 32'({ram_addr, note_idx}), 32'({2'd3, 2'd3}));

        // ---------------- 6: asynchronous reset mid-PLAY ----------------
        repeat (3) tick();                            // PLAY of note 3
        #3 rst = 1'b1;
        #1;
        check("t6_async_ctrl", 32'({fcw_valid, ram_rd_en, ram_wr_en, ram_addr, note_idx}), 0);
        check("t6_async_fcw", 32'(fcw), 0);
        check("t6_async_wr_data", 32'(ram_wr_data), 0);
        tick();
        rst = 1'b0;
        tick();
        expect_note(2'd0, 24'h00EC3C);
        pulse_pp();
        check("t6_restart_addr0", 32'({ram_rd_en, ram_addr}), 32'({1'b1, 2'd0}));

        // ---------------- 4: edit_up in PLAY of note 0 ----------------
        repeat (3) tick();                            // F+3, PLAY
        exp_wr_q.push_back({2'd0, 24'h00EC4C});
        edit_up = 1'b1;
        tick();                                       // F+4, WRITE
        edit_up = 1'b0;
        check("t4_write_cycle", 32'(ram_wr_en), 1);
        tick();                                       // F+5
        check("t4_fcw_edited", 32'({fcw_valid, fcw}), 32'({1'b1, 24'h00EC4C}));
        check("t4_single_write", 32'(ram_wr_en), 0);
        expect_note(2'd1, 24'h010905);
        wait_fetch(n);
        check("t4_note_period", 32'(5 + n), 7);
        expect_note(2'd2, 24'h01194B);
        wait_fetch(n);
        expect_note(2'd3, 24'h013BCD);
        wait_fetch(n);
        expect_note(2'd0, 24'h00EC4C);
        wrap_fetch();
        repeat (3) tick();

        // ---------------- 5: saturation and dropped edits ----------------
        rst = 1'b1;
        pre_en = 1'b1;
        pre_addr = 2'd0;
        pre_data = 24'h000008;
        tick();
        pre_addr = 2'd1;
        pre_data = 24'hFFFFF8;
        tick();
        pre_en = 1'b0;
        rst = 1'b0;
        tick();
        expect_note(2'd0, 24'h000008);
        pulse_pp();                                   // F
        repeat (2) tick();                            // F+2 PLAY
        pulse_pp();                                   // F+3 PAUSE
        check("t5_pause_hold", 32'({fcw_valid, fcw}), 32'({1'b0, 24'h000008}));
        exp_wr_q.push_back({2'd0, 24'h000000});
        edit_down = 1'b1;
        tick();                                       // WRITE
        edit_down = 1'b0;
        tick();                                       // back in PAUSE
        check("t5_sat_low_fcw", 32'({fcw_valid, fcw}), 0);
        edit_up = 1'b1;
        edit_down = 1'b1;
        tick();
        edit_up = 1'b0;
        edit_down = 1'b0;
        check("t5_both_no_write", 32'(ram_wr_en), 0);
        tick();
        check("t5_both_fcw_held", 32'({ram_wr_en, fcw}), 0);
        expect_note(2'd1, 24'hFFFFF8);
        pulse_pp();
        check("t5_resume_valid", 32'(fcw_valid), 1);
        wait_fetch(n);                                // F' fetch note 1
        repeat (2) tick();                            // F'+2 PLAY
        exp_wr_q.push_back({2'd1, 24'hFFFFFF});
        edit_up = 1'b1;
        tick();
        edit_up = 1'b0;
        tick();
        check("t5_sat_high_fcw", 32'({fcw_valid, fcw}), 32'({1'b1, 24'hFFFFFF}));
        // edit coincident with play_pause is dropped
        edit_down = 1'b1;
        play_pause = 1'b1;
        tick();
        edit_down = 1'b0;
        play_pause = 1'b0;
        check("t5_pp_edit_dropped", 32'({fcw_valid, ram_wr_en}), 0);
        tick();
        check("t5_pp_edit_no_late_write", 32'({ram_wr_en, fcw}), 32'({1'b0, 24'hFFFFFF}));
        repeat (3) tick();

        check("ram0_after_edits", 32'(mem[0]), 0);
        check("ram1_after_edits", 32'(mem[1]), 32'(24'hFFFFFF));
        check("rd_queue_drained", 32'(exp_rd_q.size()), 0);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 0);
        check("fcw_queue_drained", 32'(exp_fcw_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
